// File: rtl/mem_pkg.sv
// Shared types and helpers for the word-over-byte memory adapter.
// The byte-select helper is width-generic so the same function serves write lanes and read assembly.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_LAST,
    DONE
  } state_e;

  localparam int DEF_BYTE_W         = 8;
  localparam int DEF_BYTES_PER_WORD = 4;
  localparam int DEF_WORD_ADDR_W    = 4;
  localparam int SEL_MAX_W          = 1024;

  // Returns byte k of word (address order); callers cast the result down to their byte width.
  function automatic logic [SEL_MAX_W-1:0] byte_select(
    input logic [SEL_MAX_W-1:0] word,
    input int                   k,
    input bit                   big_endian,
    input int                   byte_w,
    input int                   n
  );
    int lane;
    lane = big_endian ? (n - 1 - k) : k;
    return word >> (lane * byte_w);
  endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Single-port byte-wide synchronous RAM with registered read data.
// Read-during-write returns the previous contents; the array is never reset.
module mem_byte_ram #(
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/mem_word_adapter.sv
// Word-wide command front end that serialises each write/read into one byte-wide
// RAM access per clock, with byte enables, selectable byte order and status pulses.
module mem_word_adapter
  import mem_pkg::*;
#(
  parameter int BYTE_W         = DEF_BYTE_W,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int WORD_ADDR_W    = DEF_WORD_ADDR_W,
  parameter bit BIG_ENDIAN     = 1'b0,
  localparam int WORD_W        = BYTE_W * BYTES_PER_WORD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr,
  input  logic                      rd,
  input  logic [WORD_ADDR_W-1:0]    InAddr,
  input  logic [WORD_W-1:0]         InData,
  input  logic [BYTES_PER_WORD-1:0] be,
  output logic [WORD_W-1:0]         dataout,
  output logic [BYTE_W-1:0]         datain,
  output logic                      valid,
  output logic                      busy,
  output logic                      err
);

  localparam int CNT_W    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int BA_W     = WORD_ADDR_W + CNT_W;
  localparam int DEPTH    = (2 ** WORD_ADDR_W) * BYTES_PER_WORD;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      wr_q, rd_q;
  logic                      wr_rise_q, rd_rise_q;
  logic                      valid_q, busy_q, err_q;
  logic                      err_d;
  logic [WORD_W-1:0]         dataout_q, dataout_d;

  logic [BA_W-1:0]           base_q, base_d;
  logic [WORD_W-1:0]         data_q, data_d;
  logic [BYTES_PER_WORD-1:0] be_q, be_d;
  logic [WORD_W-1:0]         asm_q, asm_d;
  logic [WORD_W-1:0]         asm_full;

  logic [BA_W-1:0]           ram_addr;
  logic                      ram_we;
  logic [BYTE_W-1:0]         wr_byte;
  logic [BYTE_W-1:0]         datain_w;
  logic [BYTE_W-1:0]         ram_dout;

  mem_byte_ram #(
    .BYTE_W (BYTE_W),
    .DEPTH  (DEPTH),
    .ADDR_W (BA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (datain_w),
    .dout (ram_dout)
  );

  always_comb begin
    wr_byte  = BYTE_W'(byte_select(SEL_MAX_W'(data_q), int'(count_q), BIG_ENDIAN,
                                   BYTE_W, BYTES_PER_WORD));
    ram_addr = base_q + BA_W'(count_q);
    ram_we   = (state_q == WRITE) && be_q[count_q];
    datain_w = (state_q == WRITE) ? wr_byte : '0;
  end

  // Read bytes arrive one cycle after their address and shift in from the top.
  assign asm_full = {ram_dout, asm_q[WORD_W-1:BYTE_W]};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    base_d    = base_q;
    data_d    = data_q;
    be_d      = be_q;
    asm_d     = asm_q;
    dataout_d = dataout_q;
    err_d     = wr_rise_q | rd_rise_q;

    unique case (state_q)
      IDLE: begin
        err_d = wr_rise_q & rd_rise_q;
        if (wr_rise_q ^ rd_rise_q) begin
          state_d = wr_rise_q ? WRITE : READ;
          base_d  = BA_W'(InAddr) * BA_W'(BYTES_PER_WORD);
          data_d  = InData;
          be_d    = be;
          count_d = '0;
        end
      end
      WRITE: begin
        if (count_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      READ: begin
        if (count_q != '0) begin
          asm_d = asm_full;
        end
        if (count_q == LAST_CNT) begin
          state_d = READ_LAST;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      READ_LAST: begin
        asm_d = asm_full;
        for (int j = 0; j < BYTES_PER_WORD; j++) begin
          dataout_d[j*BYTE_W +: BYTE_W] = BYTE_W'(byte_select(SEL_MAX_W'(asm_full), j,
                                                              BIG_ENDIAN, BYTE_W,
                                                              BYTES_PER_WORD));
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_rise_q <= 1'b0;
      rd_rise_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      dataout_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_q      <= wr;
      rd_q      <= rd;
      wr_rise_q <= wr & ~wr_q;
      rd_rise_q <= rd & ~rd_q;
      valid_q   <= (state_d == DONE);
      busy_q    <= (state_d != IDLE);
      err_q     <= err_d;
      dataout_q <= dataout_d;
    end
  end

  // Command payload and assembly register carry no control meaning, so they skip reset.
  always_ff @(posedge clk) begin
    base_q <= base_d;
    data_q <= data_d;
    be_q   <= be_d;
    asm_q  <= asm_d;
  end

  assign dataout = dataout_q;
  assign datain  = datain_w;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
